pkt_bus_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single `packet_parser` input bus between `NUM_REQ` independent packet sources. A grant is taken on a requester's SOP beat and held until that requester's EOP beat, so packets from different sources never interleave. All `bus_out_*` fields are registered and connect directly to the parser's `bus_in_*` ports. The parser has no backpressure, so flow control exists only on the requester side.

---
 rtl/pkt_bus_arb_pkg.sv | 39 +++
 rtl/pkt_bus_arbiter_rr_pick.sv | 26 ++
 rtl/pkt_bus_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_pkt_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_bus_arb_pkg.sv
// Purpose: shared types and helpers for the packet bus arbiter and its round-robin picker.
// Latency: n/a (types, constants and one combinational function).
// Backpressure: n/a.
package pkt_bus_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } pkt_arb_state_e;

  localparam int WIDTH_BITS_PER_BYTE = 8;

  // Widest requester set the picker supports; narrower sets are zero-padded.
  localparam int RR_MAX_REQ = 16;

  typedef struct packed {
    logic       any;
    logic [3:0] idx;
  } rr_result_t;

  // First set bit of req_mask searching upward from last+1, wrapping.
  // Zero padding above the real requester count is skipped by the search,
  // so wrapping at 16 behaves exactly like wrapping at the real count.
  function automatic rr_result_t rr_next(input logic [15:0] req_mask,
                                         input logic [3:0]  last);
    rr_result_t res;
    logic [3:0] pos;
    res = '0;
    for (int k = 1; k <= RR_MAX_REQ; k++) begin
      pos = last + 4'(k);
      if (!res.any && req_mask[pos]) begin
        res.any = 1'b1;
        res.idx = pos;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pkt_bus_arbiter_rr_pick.sv
// Purpose: combinational round-robin priority picker (rr_pick), up to 16 requesters.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; caller decides what to do with the winner.
// Ports: mask (candidate set), last (previous winner) -> winner, any (mask non-zero).
module rr_pick
  import pkt_bus_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    mask,
  input  logic [ID_W-1:0] last,
  output logic [ID_W-1:0] winner,
  output logic            any
);

  rr_result_t w_res;

  always_comb begin
    w_res = rr_next(16'(mask), 4'(last));
  end

  assign winner = ID_W'(w_res.idx);
  assign any    = w_res.any;

endmodule

// File: rtl/pkt_bus_arbiter.sv
// Purpose: packet-granular round-robin arbiter sharing one parser input bus among NUM_REQ sources.
// Latency: 1 cycle from accepted beat to bus_out_*, all outputs straight from flops.
// Backpressure: per-requester req_ready only; the parser side has no backpressure.
// Ports: clk_host/rst (sync, active-high); req_valid/sop/eop/byteen/data in, req_ready out;
//        bus_out_valid/sop/eop/byteen/data and grant_id to the parser; err_proto/err_req_id.
// Optional: define PKT_BUS_ARB_PROTOCOL_CHECK_EN to build the sticky protocol checker;
//           otherwise err_proto/err_req_id are tied to 0.
module pkt_bus_arbiter
  import pkt_bus_arb_pkg::*;
#(
  parameter  int NUM_REQ          = 4,
  parameter  int WIDTH_DATA_BYTES = 8,
  localparam int ID_W             = $clog2(NUM_REQ),
  localparam int DW               = WIDTH_DATA_BYTES * WIDTH_BITS_PER_BYTE
) (
  input  logic                                  clk_host,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0]                    req_sop,
  input  logic [NUM_REQ-1:0]                    req_eop,
  input  logic [NUM_REQ*WIDTH_DATA_BYTES-1:0]   req_byteen,
  input  logic [NUM_REQ*DW-1:0]                 req_data,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic                                  bus_out_valid,
  output logic                                  bus_out_sop,
  output logic                                  bus_out_eop,
  output logic [WIDTH_DATA_BYTES-1:0]           bus_out_byteen,
  output logic [DW-1:0]                         bus_out_data,
  output logic [ID_W-1:0]                       grant_id,
  output logic                                  err_proto,
  output logic [ID_W-1:0]                       err_req_id
);

  pkt_arb_state_e r_state, w_state_nxt;
  logic [ID_W-1:0] r_owner, w_owner_nxt;
  logic [ID_W-1:0] r_last, w_last_nxt;

  logic [NUM_REQ-1:0]          w_cand;
  logic [ID_W-1:0]             w_winner;
  logic                        w_any;
  logic [ID_W-1:0]             w_sel;
  logic                        w_sel_valid, w_sel_sop, w_sel_eop;
  logic [WIDTH_DATA_BYTES-1:0] w_sel_be;
  logic [DW-1:0]               w_sel_data;
  logic [NUM_REQ-1:0]          w_ready;
  logic                        w_acc;

  // Only SOP beats may open a grant.
  assign w_cand = req_valid & req_sop;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .mask   (w_cand),
    .last   (r_last),
    .winner (w_winner),
    .any    (w_any)
  );

  // The beat under consideration comes from the picker when idle, the owner when locked.
  assign w_sel = (r_state == IDLE) ? w_winner : r_owner;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_sop   = 1'b0;
    w_sel_eop   = 1'b0;
    w_sel_be    = '0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == ID_W'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_sop   = req_sop[i];
        w_sel_eop   = req_eop[i];
        w_sel_be    = req_byteen[i*WIDTH_DATA_BYTES +: WIDTH_DATA_BYTES];
        w_sel_data  = req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk_host) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= ID_W'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Ready depends only on state plus req_valid/req_sop (through the picker);
  // eop only steers the next state, never the ready bits.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_ready     = '0;
    w_acc       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_ready[w_winner] = 1'b1;
          w_acc             = 1'b1;
          if (w_sel_eop) begin
            w_last_nxt = w_winner;
          end else begin
            w_state_nxt = LOCKED;
            w_owner_nxt = w_winner;
          end
        end
      end
      LOCKED: begin
        // Grant is held across owner bubbles until its EOP is accepted.
        w_ready[r_owner] = 1'b1;
        w_acc            = w_sel_valid;
        if (w_sel_valid && w_sel_eop) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_owner;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign req_ready = w_ready;

  always_ff @(posedge clk_host) begin
    if (rst) begin
      bus_out_valid  <= 1'b0;
      bus_out_sop    <= 1'b0;
      bus_out_eop    <= 1'b0;
      bus_out_byteen <= '0;
      bus_out_data   <= '0;
      grant_id       <= '0;
    end else if (w_acc) begin
      bus_out_valid  <= 1'b1;
      bus_out_sop    <= w_sel_sop;
      bus_out_eop    <= w_sel_eop;
      bus_out_byteen <= w_sel_be;
      bus_out_data   <= w_sel_data;
      grant_id       <= w_sel;
    end else begin
      // grant_id keeps the last owner so it still names the most recent beat.
      bus_out_valid  <= 1'b0;
      bus_out_sop    <= 1'b0;
      bus_out_eop    <= 1'b0;
      bus_out_byteen <= '0;
      bus_out_data   <= '0;
    end
  end

`ifdef PKT_BUS_ARB_PROTOCOL_CHECK_EN
  logic            r_err;
  logic [ID_W-1:0] r_err_id;
  logic            w_viol;
  logic [ID_W-1:0] w_viol_id;

  // Lowest-index non-owner offender wins; an owner re-issuing SOP mid-packet
  // takes precedence since it corrupts the packet actually on the bus.
  always_comb begin
    w_viol    = 1'b0;
    w_viol_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && !req_sop[i] &&
          !(r_state == LOCKED && r_owner == ID_W'(i))) begin
        w_viol    = 1'b1;
        w_viol_id = ID_W'(i);
      end
    end
    if (r_state == LOCKED && w_sel_valid && w_sel_sop) begin
      w_viol    = 1'b1;
      w_viol_id = r_owner;
    end
  end

  always_ff @(posedge clk_host) begin
    if (rst) begin
      r_err    <= 1'b0;
      r_err_id <= '0;
    end else if (!r_err && w_viol) begin
      r_err    <= 1'b1;
      r_err_id <= w_viol_id;
    end
  end

  assign err_proto  = r_err;
  assign err_req_id = r_err_id;
`else
  assign err_proto  = 1'b0;
  assign err_req_id = '0;
`endif

endmodule

// File: tb/tb_pkt_bus_arbiter.sv
// Purpose: directed self-checking bench for pkt_bus_arbiter (4 requesters, 8-byte bus).
// Latency: expects bus_out one cycle after each accepted beat.
// Backpressure: checks req_ready grant/hold behaviour per requester.
module tb_pkt_bus_arbiter;

  localparam int NR = 4;
  localparam int WB = 8;
  localparam int DW = 64;
  localparam int IW = 2;

`ifdef PKT_BUS_ARB_PROTOCOL_CHECK_EN
  localparam logic          EXP_ERR    = 1'b1;
  localparam logic [IW-1:0] EXP_ERR_ID = 2'd2;
`else
  localparam logic          EXP_ERR    = 1'b0;
  localparam logic [IW-1:0] EXP_ERR_ID = 2'd0;
`endif

  logic              clk_host = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_sop, req_eop, req_ready;
  logic [NR*WB-1:0]  req_byteen;
  logic [NR*DW-1:0]  req_data;
  logic              bus_out_valid, bus_out_sop, bus_out_eop;
  logic [WB-1:0]     bus_out_byteen;
  logic [DW-1:0]     bus_out_data;
  logic [IW-1:0]     grant_id;
  logic              err_proto;
  logic [IW-1:0]     err_req_id;

  int checks = 0;
  int errors = 0;

  logic [7:0] t1_be [4];

  always #5 clk_host = ~clk_host;

  pkt_bus_arbiter #(.NUM_REQ(NR), .WIDTH_DATA_BYTES(WB)) dut (
    .clk_host       (clk_host),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_sop        (req_sop),
    .req_eop        (req_eop),
    .req_byteen     (req_byteen),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .bus_out_valid  (bus_out_valid),
    .bus_out_sop    (bus_out_sop),
    .bus_out_eop    (bus_out_eop),
    .bus_out_byteen (bus_out_byteen),
    .bus_out_data   (bus_out_data),
    .grant_id       (grant_id),
    .err_proto      (err_proto),
    .err_req_id     (err_req_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_host);
    #1;
  endtask

  task automatic clr();
    req_valid  = '0;
    req_sop    = '0;
    req_eop    = '0;
    req_byteen = '0;
    req_data   = '0;
  endtask

  task automatic drv(input int i, input logic s, input logic e,
                     input logic [7:0] be, input logic [63:0] d);
    req_valid[i]          = 1'b1;
    req_sop[i]            = s;
    req_eop[i]            = e;
    req_byteen[i*WB +: WB] = be;
    req_data[i*DW +: DW]   = d;
  endtask

  function automatic logic [63:0] mk(input int i, input int b);
    return 64'hD000_0000_0000_0000 | (64'(i) << 32) | 64'(b);
  endfunction

  task automatic chk_rdy(input string tag, input logic [NR-1:0] exp);
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(exp));
  endtask

  task automatic chk_out(input string tag, input logic s, input logic e,
                         input logic [7:0] be, input logic [63:0] d, input logic [IW-1:0] gid);
    chk({tag, "_valid"},  64'(bus_out_valid),  64'd1);
    chk({tag, "_sop"},    64'(bus_out_sop),    64'(s));
    chk({tag, "_eop"},    64'(bus_out_eop),    64'(e));
    chk({tag, "_byteen"}, 64'(bus_out_byteen), 64'(be));
    chk({tag, "_data"},   bus_out_data,        d);
    chk({tag, "_gid"},    64'(grant_id),       64'(gid));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"},  64'(bus_out_valid),  64'd0);
    chk({tag, "_sop"},    64'(bus_out_sop),    64'd0);
    chk({tag, "_eop"},    64'(bus_out_eop),    64'd0);
    chk({tag, "_byteen"}, 64'(bus_out_byteen), 64'd0);
    chk({tag, "_data"},   bus_out_data,        64'd0);
  endtask

  initial begin
    t1_be[0] = 8'hFF; t1_be[1] = 8'hFF; t1_be[2] = 8'hFF; t1_be[3] = 8'hFE;

    // Reset state
    clr();
    rst = 1'b1;
    step(); step();
    chk_empty("rst");
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_err", 64'(err_proto), 64'd0);
    chk("rst_err_id", 64'(err_req_id), 64'd0);
    chk_rdy("rst", 4'b0000);
    rst = 1'b0;

    // T1: requester 0 sends a 4-beat packet
    for (int b = 0; b < 4; b++) begin
      clr();
      drv(0, b == 0, b == 3, t1_be[b], mk(0, b));
      chk_rdy("t1", 4'b0001);
      step();
      chk_out("t1", b == 0, b == 3, t1_be[b], mk(0, b), 2'd0);
    end
    clr();
    step();
    chk_empty("t1_end");

    // T2: 0 and 2 collide after reset; 0 wins, 2 follows with no bubble
    rst = 1'b1; step(); rst = 1'b0;
    clr();
    drv(0, 1'b1, 1'b0, 8'hFF, mk(0, 0));
    drv(2, 1'b1, 1'b1, 8'h0F, mk(2, 0));
    chk_rdy("t2_c0", 4'b0001);
    step();
    chk_out("t2_b0", 1'b1, 1'b0, 8'hFF, mk(0, 0), 2'd0);
    drv(0, 1'b0, 1'b1, 8'hFF, mk(0, 1));
    chk_rdy("t2_c1", 4'b0001);
    step();
    chk_out("t2_b1", 1'b0, 1'b1, 8'hFF, mk(0, 1), 2'd0);
    clr();
    drv(2, 1'b1, 1'b1, 8'h0F, mk(2, 0));
    chk_rdy("t2_c2", 4'b0100);
    step();
    chk_out("t2_b2", 1'b1, 1'b1, 8'h0F, mk(2, 0), 2'd2);
    clr();
    step();
    chk_empty("t2_end");

    // T3: all four stream single-beat packets; grant rotates 0,1,2,3,...
    rst = 1'b1; step(); rst = 1'b0;
    clr();
    for (int i = 0; i < NR; i++) drv(i, 1'b1, 1'b1, 8'hFF, mk(i, 0));
    for (int k = 0; k < 8; k++) begin
      chk_rdy("t3", 4'(1 << (k % 4)));
      step();
      chk_out("t3", 1'b1, 1'b1, 8'hFF, mk(k % 4, 0), 2'(k % 4));
    end
    clr();
    step();
    chk_empty("t3_end");

    // T4: owner 1 bubbles for 2 cycles while 3 waits with SOP
    clr();
    drv(1, 1'b1, 1'b0, 8'hFF, mk(1, 0));
    drv(3, 1'b1, 1'b1, 8'hFF, mk(3, 0));
    chk_rdy("t4_c0", 4'b0010);
    step();
    chk_out("t4_b0", 1'b1, 1'b0, 8'hFF, mk(1, 0), 2'd1);
    req_valid[1] = 1'b0;
    chk_rdy("t4_gap0", 4'b0010);
    step();
    chk_empty("t4_gap0");
    chk_rdy("t4_gap1", 4'b0010);
    step();
    chk_empty("t4_gap1");
    drv(1, 1'b0, 1'b1, 8'hF0, mk(1, 1));
    chk_rdy("t4_c3", 4'b0010);
    step();
    chk_out("t4_b1", 1'b0, 1'b1, 8'hF0, mk(1, 1), 2'd1);
    clr();
    drv(3, 1'b1, 1'b1, 8'hFF, mk(3, 0));
    chk_rdy("t4_c4", 4'b1000);
    step();
    chk_out("t4_b3", 1'b1, 1'b1, 8'hFF, mk(3, 0), 2'd3);
    clr();
    step();
    chk_empty("t4_end");

    // T5: reset during beat 2 of a 5-beat packet
    clr();
    drv(0, 1'b1, 1'b0, 8'hFF, mk(0, 0));
    chk_rdy("t5_c0", 4'b0001);
    step();
    chk_out("t5_b0", 1'b1, 1'b0, 8'hFF, mk(0, 0), 2'd0);
    drv(0, 1'b0, 1'b0, 8'hFF, mk(0, 1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_empty("t5_rst");
    chk("t5_rst_gid", 64'(grant_id), 64'd0);
    chk_rdy("t5_mid_after_rst", 4'b0000);
    step();
    chk_empty("t5_mid_after_rst");
    clr();
    drv(0, 1'b1, 1'b1, 8'h3F, mk(0, 9));
    chk_rdy("t5_new", 4'b0001);
    step();
    chk_out("t5_new", 1'b1, 1'b1, 8'h3F, mk(0, 9), 2'd0);
    clr();
    step();

    // T6: protocol check, requester 2 valid without SOP while idle
    rst = 1'b1; step(); rst = 1'b0;
    clr();
    drv(2, 1'b0, 1'b0, 8'hFF, mk(2, 5));
    chk_rdy("t6", 4'b0000);
    step();
    chk_empty("t6");
    chk("t6_err", 64'(err_proto), 64'(EXP_ERR));
    chk("t6_err_id", 64'(err_req_id), 64'(EXP_ERR_ID));
    clr();
    step();
    chk("t6_err_sticky", 64'(err_proto), 64'(EXP_ERR));
    chk("t6_err_id_sticky", 64'(err_req_id), 64'(EXP_ERR_ID));
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_err_clr", 64'(err_proto), 64'd0);
    chk("t6_err_id_clr", 64'(err_req_id), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
